ccr_flag_unit: RTL and testbench
================================

Name: ccr_flag_unit

Overview:
- Condition-code register on the consuming end of the ALU flag interface.
- Captures the zero, negative, carry and overflow flags from the ALU under a per-flag write mask and holds them across instructions.
- Feeds the held carry back to the ALU for rotate-through-carry.
- Evaluates conditional-branch predicates and clears the tested flag on a taken branch.
- Saves and restores flags on interrupt entry and return through a small internal stack.

Parameters:
SAVE_DEPTH, 2, number of flag snapshots the save/restore stack holds (nested interrupt depth, >=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
alu_zero  input  1  ALU zero flag for the current result
alu_neg  input  1  ALU negative flag
alu_cout  input  1  ALU carry-out
alu_overflow  input  1  ALU signed overflow
flag_valid  input  1  ALU result belongs to a committed instruction (low on stall/flush)
flag_we  input  4  per-flag update mask, bit order {V,C,N,Z}
save  input  1  interrupt entry: push flags
restore  input  1  return-from-interrupt: pop flags
cond_check  input  1  conditional branch present this cycle
cond_sel  input  3  000 Z, 001 N, 010 C, 011 V, 100 always, others never
flags  output  4  held flags {V,C,N,Z}
carry_to_alu  output  1  equals flags[2], combinational from register
branch_taken  output  1  combinational predicate result
stack_full  output  1  stack holds SAVE_DEPTH entries
stack_empty  output  1  stack holds 0 entries
stack_err  output  1  sticky error flag

Behaviour:
- Reset (async, active-high) clears:
  - flags to 0000 and the stack pointer to 0.
  - stack_err to 0.
  - stack_empty=1, stack_full=0, carry_to_alu=0.
  - branch_taken=0 after reset because flags are 0, except cond_sel=100, which gives 1.
- branch_taken = cond_check & selected predicate:
  - Z/N/C/V codes test the held flag.
  - cond_sel=100 gives 1 whenever cond_check=1; codes 101-111 give 0.
  - No latency.
- Next-flag computation, per bit i, in priority order:
  1. restore accepted: bit = popped snapshot bit.
  2. flag_valid & flag_we[i]: bit = ALU flag.
  3. branch_taken & cond_sel selects bit i (codes 000-011 only): bit = 0.
  4. Otherwise hold.
- ALU update beats branch clear on the same bit. Both apply when the bits differ.
- Save (push):
  - When save=1, restore=0 and not full, the post-update next-flag value is written to stack[sp] and sp increments. An interrupted instruction's result is therefore preserved.
  - If full, there is no push and stack_err is set.
- Restore (pop):
  - When restore=1 and not empty, sp decrements and flags load stack[sp-1], overriding any ALU update or branch clear that cycle.
  - If empty, there is no pop, flags follow the normal rules, and stack_err is set.
- save and restore together: restore wins, save is ignored, stack_err is set.
- stack_err is sticky; only reset clears it.
- Stack entries are not cleared on pop; contents above sp are don't-care.
- flag_we bits are ignored when flag_valid=0.
- Reset mid-operation discards all snapshots immediately; there is no pending push or pop after reset deasserts.
- One-cycle visibility: a flag written at edge n is seen by carry_to_alu/branch_taken during cycle n+1.

Test Plan:
- Reset, then flag_valid=1, flag_we=1111, ALU V,C,N,Z=0,1,1,0 -> next cycle flags=0110, carry_to_alu=1.
- flags=0001, cond_check=1, cond_sel=000 -> branch_taken=1 same cycle; next cycle flags=0000. Repeat with cond_sel=101 -> branch_taken=0, flags unchanged.
- flags=0001, same cycle: branch on Z taken plus flag_valid, flag_we=0001, alu_zero=1 -> flags stays 0001 (ALU beats clear).
- flags=1010, save=1 with flag_valid, flag_we=0001, alu_zero=1 -> flags=1011, stack holds 1011. Later flags=0000, then restore=1 -> flags=1011, stack_empty=1.
- SAVE_DEPTH=2: push three times -> stack_full=1 after the second push, stack_err=1 after the third, sp stays 2. Then restore with an ALU update (flag_we=1111, ALU flags=0000) in the same cycle -> flags=second snapshot.
- Reset asserted asynchronously mid-cycle with stack holding 1 entry -> flags=0000, stack_empty=1, stack_err=0 immediately; restore after release -> stack_err=1.

Source files
------------

// File: rtl/ccr_flag_unit.sv
// Condition-code register: masked ALU flag capture, branch predicate with
// clear-on-taken, and a small save/restore stack for interrupt nesting.
module ccr_flag_unit #(
  parameter int unsigned SAVE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       alu_cout,
  input  logic       alu_overflow,
  input  logic       flag_valid,
  input  logic [3:0] flag_we,
  input  logic       save,
  input  logic       restore,
  input  logic       cond_check,
  input  logic [2:0] cond_sel,
  output logic [3:0] flags,
  output logic       carry_to_alu,
  output logic       branch_taken,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  localparam int unsigned SPW = $clog2(SAVE_DEPTH + 1);

  logic [3:0]     flags_q, flags_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [3:0]     stack_q [SAVE_DEPTH];
  logic [3:0]     stack_d [SAVE_DEPTH];

  logic [3:0] alu_flags;
  logic [3:0] popped;
  logic       pred;
  logic       full, empty;
  logic       pop_ok, push_ok;

  assign alu_flags = {alu_overflow, alu_cout, alu_neg, alu_zero};
  assign full      = (sp_q == SPW'(SAVE_DEPTH));
  assign empty     = (sp_q == '0);
  assign pop_ok    = restore & ~empty;
  assign push_ok   = save & ~restore & ~full;

  always_comb begin
    case (cond_sel)
      3'b000:  pred = flags_q[0];
      3'b001:  pred = flags_q[1];
      3'b010:  pred = flags_q[2];
      3'b011:  pred = flags_q[3];
      3'b100:  pred = 1'b1;
      default: pred = 1'b0;
    endcase
  end

  assign branch_taken = cond_check & pred;

  // Index by comparison against sp so the stack works for any depth,
  // including SAVE_DEPTH=1 where a narrower index would be zero width.
  always_comb begin
    popped = '0;
    for (int unsigned i = 0; i < SAVE_DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) popped = stack_q[i];
    end

    flags_d = flags_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (branch_taken && (cond_sel == 3'(i))) flags_d[i] = 1'b0;
      if (flag_valid && flag_we[i])            flags_d[i] = alu_flags[i];
    end
    if (pop_ok) flags_d = popped;

    stack_d = stack_q;
    for (int unsigned i = 0; i < SAVE_DEPTH; i++) begin
      if (push_ok && (sp_q == SPW'(i))) stack_d[i] = flags_d;
    end

    sp_d = sp_q;
    if (pop_ok)       sp_d = sp_q - SPW'(1);
    else if (push_ok) sp_d = sp_q + SPW'(1);

    err_d = err_q | (save & restore) | (restore & empty) | (save & ~restore & full);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < SAVE_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      flags_q <= flags_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign flags        = flags_q;
  assign carry_to_alu = flags_q[2];
  assign stack_full   = full;
  assign stack_empty  = empty;
  assign stack_err    = err_q;

endmodule

// File: tb/tb_ccr_flag_unit.sv
// Bench for ccr_flag_unit: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based flag model.
module tb_ccr_flag_unit;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alu_zero = 1'b0, alu_neg = 1'b0, alu_cout = 1'b0, alu_overflow = 1'b0;
  logic       flag_valid = 1'b0;
  logic [3:0] flag_we = '0;
  logic       save = 1'b0, restore = 1'b0, cond_check = 1'b0;
  logic [2:0] cond_sel = '0;
  logic [3:0] flags;
  logic       carry_to_alu, branch_taken, stack_full, stack_empty, stack_err;

  ccr_flag_unit #(.SAVE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .flag_valid(flag_valid), .flag_we(flag_we),
    .save(save), .restore(restore),
    .cond_check(cond_check), .cond_sel(cond_sel),
    .flags(flags), .carry_to_alu(carry_to_alu), .branch_taken(branch_taken),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          chk_en = 1'b0;

  // Reference model: held flags, snapshot queue (back = top), sticky error.
  logic [3:0] m_flags = '0;
  logic [3:0] m_stack [$];
  bit         m_err = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flags = '0;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] alu, nf;
      logic       exp_bt;
      alu = {alu_overflow, alu_cout, alu_neg, alu_zero};
      if (cond_sel < 3'd4) exp_bt = cond_check & m_flags[cond_sel[1:0]];
      else                 exp_bt = cond_check & (cond_sel == 3'd4);
      check("m_flags", flags, m_flags);
      check("m_carry", carry_to_alu, m_flags[2]);
      check("m_branch", branch_taken, exp_bt);
      check("m_full", stack_full, m_stack.size() == DEPTH);
      check("m_empty", stack_empty, m_stack.size() == 0);
      check("m_err", stack_err, m_err);
      nf = m_flags;
      if (exp_bt && cond_sel < 3'd4) nf[cond_sel[1:0]] = 1'b0;
      for (int i = 0; i < 4; i++)
        if (flag_valid && flag_we[i]) nf[i] = alu[i];
      if (restore) begin
        if (m_stack.size() > 0) nf = m_stack.pop_back();
        else m_err = 1'b1;
        if (save) m_err = 1'b1;
      end else if (save) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(nf);
        else m_err = 1'b1;
      end
      m_flags = nf;
    end
  end

  // alu given as {V,C,N,Z}
  task automatic drive(input logic [3:0] alu, input logic fv, input logic [3:0] we,
                       input logic sv, input logic rs, input logic cc, input logic [2:0] sel);
    {alu_overflow, alu_cout, alu_neg, alu_zero} = alu;
    flag_valid = fv; flag_we = we; save = sv; restore = rs;
    cond_check = cc; cond_sel = sel;
  endtask

  task automatic idle();
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_flags", flags, 4'b0000);
    check("rst_empty", stack_empty, 1'b1);
    check("rst_full", stack_full, 1'b0);
    check("rst_err", stack_err, 1'b0);
    check("rst_carry", carry_to_alu, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 3'b100); #1;
    check("rst_bt_always", branch_taken, 1'b1);
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 3'b000); #1;
    check("rst_bt_z", branch_taken, 1'b0);
    chk_en = 1'b1;

    // ALU capture and carry feedback
    drive(4'b0110, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 3'b000); tick();
    check("cap_flags", flags, 4'b0110);
    check("cap_carry", carry_to_alu, 1'b1);

    // Taken branch on Z clears Z
    drive(4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 3'b000); tick();
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 3'b000); #1;
    check("bz_taken", branch_taken, 1'b1);
    tick();
    check("bz_clear", flags, 4'b0000);

    // Code 101 never taken, nothing cleared
    drive(4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 3'b000); tick();
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 3'b101); #1;
    check("b101_taken", branch_taken, 1'b0);
    tick();
    check("b101_hold", flags, 4'b0001);

    // ALU update beats branch clear on the same bit
    drive(4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 3'b000); tick();
    check("alu_beats_clr", flags, 4'b0001);

    // Save captures post-update value, restore brings it back
    drive(4'b1010, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 3'b000); tick();
    drive(4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 3'b000); tick();
    check("save_flags", flags, 4'b1011);
    check("save_empty", stack_empty, 1'b0);
    drive(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 3'b000); tick();
    check("clr_flags", flags, 4'b0000);
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b000); tick();
    check("rest_flags", flags, 4'b1011);
    check("rest_empty", stack_empty, 1'b1);

    // Overflow the stack, then restore overrides a same-cycle ALU update
    drive(4'b0011, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 3'b000); tick();
    check("push1_full", stack_full, 1'b0);
    drive(4'b0101, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 3'b000); tick();
    check("push2_full", stack_full, 1'b1);
    check("push2_err", stack_err, 1'b0);
    drive(4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 3'b000); tick();
    check("push3_err", stack_err, 1'b1);
    check("push3_full", stack_full, 1'b1);
    drive(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 3'b000); tick();
    check("pop1_flags", flags, 4'b0101);
    check("pop1_full", stack_full, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b000); tick();
    check("pop2_flags", flags, 4'b0011);
    check("pop2_empty", stack_empty, 1'b1);

    // Async reset mid-cycle drops the stack and the sticky error
    drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 3'b000); tick();
    check("pre_rst_empty", stack_empty, 1'b0);
    idle();
    #1;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    check("arst_flags", flags, 4'b0000);
    check("arst_empty", stack_empty, 1'b1);
    check("arst_err", stack_err, 1'b0);
    tick();
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b000); tick();
    check("post_rst_err", stack_err, 1'b1);

    // Randomised traffic against the model, with occasional resets
    for (int n = 0; n < 4000; n++) begin
      if (($urandom % 500) == 0) begin
        idle();
        chk_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
      end
      drive(4'($urandom), ($urandom % 4) != 0, 4'($urandom),
            ($urandom % 4) == 0, ($urandom % 5) == 0,
            ($urandom % 2) == 0, 3'($urandom));
      tick();
    end

    idle();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
